ext_pipe: RTL and testbench
===========================

# ext_pipe

Parametrised, pipelined extension unit for the datapath. It covers immediate extension (zero, sign, upper-half placement) and load-data extension (byte or halfword lane select with sign or zero fill, plus word pass-through). It has a valid/ready handshake, a flush, and misalignment detection. It sits between decode and execute for immediates, and between data memory and writeback for loads. Two register stages give full throughput and hold data under downstream stall.

## Interface
Parameters:
- IMM_W, 16, immediate width
- DATA_W, 32, datapath width; multiple of 8, at least 2*IMM_W
- TAG_W, 5, sideband tag width (destination register number)

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all in-flight entries
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when in_valid && in_ready
- in_op  in  3  operation code (see Operation)
- in_imm  in  IMM_W  immediate operand
- in_word  in  DATA_W  load word from memory
- in_off  in  OFF_W = log2(DATA_W/8)  byte offset within in_word
- in_tag  in  TAG_W  carried unchanged to out_tag
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  DATA_W  extended result
- out_tag  out  TAG_W  tag of the result
- out_misalign  out  1  offset illegal for op; out_data is 0

## Operation
- Op codes:
  - 0 ZERO: imm zero-filled
  - 1 SIGN: imm sign-filled
  - 2 HIGHPOS: {imm, IMM_W zeros}, then sign-extended to DATA_W (at DATA_W=32 this is exactly imm<<16)
  - 3 BYTE_U, 4 BYTE_S: byte lane in_off, zero- or sign-filled
  - 5 HALF_U, 6 HALF_S: halfword lane in_off>>1, zero- or sign-filled
  - 7 WORD: in_word unchanged
- All 8 codes are defined. No latches; no hold of a previous value.
- Lane numbering is little-endian: byte k = in_word[8k+7:8k].
- Misalignment rules:
  - HALF_* with in_off[0]=1 → misaligned.
  - WORD with in_off≠0 → misaligned.
  - Immediate ops ignore in_off and in_word.
  - Misaligned result: out_misalign=1, out_data=0, out_tag carried.
- Stage 1 (S1) registers op, selected lane, sign bit, misalign flag and tag. Stage 2 (S2) registers the extended result.
- Stage control:
  - S1 advances when !s2_valid || out_ready.
  - in_ready = rstn && (!s1_valid || s1_advance), combinational.
- Flush:
  - Next edge clears s1_valid and s2_valid.
  - A request handshaken in the flush cycle is discarded.
  - Flush takes priority over all transfers.

## Timing
- Latency: result of a request accepted at edge N is presented with out_valid=1 after edge N+1, if out_ready was held high.
- Throughput is one per cycle. Capacity is 2 entries. in_ready falls only when both stages are full and out_ready=0.
- Stall: out_data, out_tag and out_misalign hold stable while out_valid && !out_ready.
- Simultaneous accept and drain in the same cycle is legal and loses no entry.
- Reset (asynchronous assert, synchronous-clean deassert):
  - s1_valid, s2_valid, out_valid, out_data, out_tag and out_misalign are 0 immediately.
  - in_ready is 0 while rstn is low and 1 on the first cycle after release.
- Reset in the middle of a transfer drops all entries; there is no partial output.

## Structure
- Package ext_pkg holds:
  - localparams for the 8 op codes: EXT_ZERO, EXT_SIGN, EXT_HIGHPOS, EXT_BYTE_U, EXT_BYTE_S, EXT_HALF_U, EXT_HALF_S, EXT_WORD
  - the op width (3)
  - a function computing OFF_W
- One sub-module, ext_lane_sel: combinational, used in S1. It takes op, word and offset, and returns the selected lane, its sign bit and the misalign flag.
- Extension and the stage registers stay in ext_pipe.

## Test plan
- Immediate ops, DATA_W=32, out_ready=1:
  - SIGN 0x8001 → 0xFFFF8001
  - ZERO 0x8001 → 0x00008001
  - HIGHPOS 0x1234 → 0x12340000
  - each result appears on the second edge after accept
- Load ops, in_word=0x80FF7F01:
  - BYTE_S off 3 → 0xFFFFFF80
  - BYTE_U off 2 → 0x000000FF
  - BYTE_S off 1 → 0x0000007F
  - HALF_S off 2 → 0xFFFF80FF
  - HALF_U off 0 → 0x00007F01
  - WORD off 0 → 0x80FF7F01
- Misalignment:
  - HALF_U off 1 → out_misalign=1, out_data=0
  - WORD off 2 → out_misalign=1
  - SIGN with off 3 → out_misalign=0
- Backpressure:
  - Stream tags 1..4 back to back; hold out_ready=0 for 3 cycles after the first out_valid.
  - in_ready drops with 2 entries held; results stay stable.
  - After release, tags arrive 1,2,3,4 with no loss or duplication.
- Flush with both stages full plus a request in the same cycle → next cycle out_valid=0, in_ready=1; none of the three results ever appears.
- Assert rstn low mid-stream → out_valid, out_data, out_tag and out_misalign are 0 before the next clock edge. After release, the first accepted request completes normally.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: op codes and sizing helpers shared by the extension pipeline
package ext_pkg;
   localparam int OP_W = 3;
   localparam logic [OP_W-1:0] EXT_ZERO    = 3'd0;
   localparam logic [OP_W-1:0] EXT_SIGN    = 3'd1;
   localparam logic [OP_W-1:0] EXT_HIGHPOS = 3'd2;
   localparam logic [OP_W-1:0] EXT_BYTE_U  = 3'd3;
   localparam logic [OP_W-1:0] EXT_BYTE_S  = 3'd4;
   localparam logic [OP_W-1:0] EXT_HALF_U  = 3'd5;
   localparam logic [OP_W-1:0] EXT_HALF_S  = 3'd6;
   localparam logic [OP_W-1:0] EXT_WORD    = 3'd7;

   function automatic int off_w(input int data_w);
      return data_w > 8 ? $clog2(data_w / 8) : 1;
   endfunction
endpackage

// File: rtl/ext_lane_sel.sv
// ext_lane_sel: picks the byte/halfword/word lane of a load word and flags misaligned offsets
module ext_lane_sel
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = off_w(DATA_W)
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] word,
   input  logic [OFF_W-1:0]  off,
   output logic [DATA_W-1:0] lane,
   output logic              sgn,
   output logic              mis
);
   logic             is_byte, is_half;
   logic [OFF_W-1:0] off_h;
   logic [7:0]       byte_l;
   logic [15:0]      half_l;

   assign is_byte = op == EXT_BYTE_U || op == EXT_BYTE_S;
   assign is_half = op == EXT_HALF_U || op == EXT_HALF_S;
   assign off_h   = off & ~OFF_W'(1);
   assign byte_l  = word[{off, 3'b000} +: 8];
   assign half_l  = word[{off_h, 3'b000} +: 16];
   assign lane    = is_byte ? DATA_W'(byte_l) : is_half ? DATA_W'(half_l) : word;
   assign sgn     = is_byte ? byte_l[7] : is_half ? half_l[15] : word[DATA_W-1];
   assign mis     = (is_half && off[0]) || (op == EXT_WORD && off != '0);
endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: two-stage immediate/load-data extension unit with valid/ready, flush and misalign detection
module ext_pipe
   import ext_pkg::*;
#(
   parameter  int IMM_W  = 16,
   parameter  int DATA_W = 32,
   parameter  int TAG_W  = 5,
   localparam int OFF_W  = off_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_word,
   input  logic [OFF_W-1:0]  in_off,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_misalign
);
   logic              s1_valid, s2_valid, s1_adv, acc;
   logic              s1_sgn, s1_mis, sel_sgn, sel_mis, is_imm, sgn_op;
   logic [OP_W-1:0]   s1_op;
   logic [TAG_W-1:0]  s1_tag;
   logic [DATA_W-1:0] s1_lane, sel_lane, mask, ext;

   ext_lane_sel #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_sel (
      .op   (in_op),
      .word (in_word),
      .off  (in_off),
      .lane (sel_lane),
      .sgn  (sel_sgn),
      .mis  (sel_mis)
   );

   assign s1_adv    = !s2_valid || out_ready;
   assign in_ready  = rstn && (!s1_valid || s1_adv);
   assign acc       = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign is_imm    = in_op == EXT_ZERO || in_op == EXT_SIGN || in_op == EXT_HIGHPOS;
   assign sgn_op    = in_op == EXT_SIGN || in_op == EXT_HIGHPOS || in_op == EXT_BYTE_S || in_op == EXT_HALF_S;

   // S1 only carries a sign bit for signed ops, so the fill mask is zero for unsigned/word ops
   assign mask = !s1_sgn ? '0 :
                 s1_op == EXT_BYTE_S ? ~DATA_W'(8'hFF) :
                 s1_op == EXT_HALF_S ? ~DATA_W'(16'hFFFF) : ~DATA_W'({IMM_W{1'b1}});
   assign ext  = s1_mis ? '0 : s1_op == EXT_HIGHPOS ? (s1_lane | mask) << IMM_W : s1_lane | mask;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid     <= 1'b0;
         s2_valid     <= 1'b0;
         s1_op        <= EXT_ZERO;
         s1_lane      <= '0;
         s1_sgn       <= 1'b0;
         s1_mis       <= 1'b0;
         s1_tag       <= '0;
         out_data     <= '0;
         out_tag      <= '0;
         out_misalign <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               out_data     <= ext;
               out_tag      <= s1_tag;
               out_misalign <= s1_mis;
            end
         end
         if (in_ready) begin
            s1_valid <= acc;
            if (acc) begin
               s1_op   <= in_op;
               s1_lane <= is_imm ? DATA_W'(in_imm) : sel_lane;
               s1_sgn  <= sgn_op && (is_imm ? in_imm[IMM_W-1] : sel_sgn);
               s1_mis  <= sel_mis;
               s1_tag  <= in_tag;
            end
         end
      end
   end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe at IMM_W=16, DATA_W=32, TAG_W=5
module tb_ext_pipe;
   typedef struct packed {
      logic [4:0]  tag;
      logic [31:0] data;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0, rstn = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, out_misalign;
   logic [2:0]  in_op = '0;
   logic [15:0] in_imm = '0;
   logic [31:0] in_word = '0, out_data;
   logic [1:0]  in_off = '0;
   logic [4:0]  in_tag = '0, out_tag;

   exp_t exp_q[$];
   exp_t cur_exp;
   int   n_vec = 0, n_bad = 0, popped = 0;

   ext_pipe #(.IMM_W(16), .DATA_W(32), .TAG_W(5)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_imm(in_imm),
      .in_word(in_word), .in_off(in_off), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_misalign(out_misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rstn || flush) exp_q.delete();
      else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               popped++;
               check("out_tag", 32'(out_tag), 32'(e.tag));
               check("out_data", out_data, e.data);
               check("out_mis", 32'(out_misalign), 32'(e.mis));
            end
         end
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
      end
   end

   task automatic send(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] w,
                       input logic [1:0] off, input logic [4:0] tag, input logic [31:0] ed, input logic em);
      logic ok;
      ok = 1'b0;
      in_op = op; in_imm = imm; in_word = w; in_off = off; in_tag = tag;
      cur_exp = '{tag: tag, data: ed, mis: em};
      in_valid = 1'b1;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
      end
      check("accept", 32'(ok), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      check("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic send_lat(input logic [2:0] op, input logic [15:0] imm, input logic [4:0] tag, input logic [31:0] ed);
      send(op, imm, 32'h0, 2'd3, tag, ed, 1'b0);
      check("lat_edge1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1 check("lat_edge2", 32'(out_valid), 32'd1);
      check("lat_data", out_data, ed);
      drain();
   endtask

   initial begin
      #1 rstn = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_tag", 32'(out_tag), 32'd0);
      check("rst_mis", 32'(out_misalign), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1 check("rel_ready", 32'(in_ready), 32'd1);

      send_lat(3'd1, 16'h8001, 5'd1, 32'hFFFF8001);
      send_lat(3'd0, 16'h8001, 5'd2, 32'h00008001);
      send_lat(3'd2, 16'h1234, 5'd3, 32'h12340000);

      send(3'd4, 16'h0, 32'h80FF7F01, 2'd3, 5'd4, 32'hFFFFFF80, 1'b0);
      send(3'd3, 16'h0, 32'h80FF7F01, 2'd2, 5'd5, 32'h000000FF, 1'b0);
      send(3'd4, 16'h0, 32'h80FF7F01, 2'd1, 5'd6, 32'h0000007F, 1'b0);
      send(3'd6, 16'h0, 32'h80FF7F01, 2'd2, 5'd7, 32'hFFFF80FF, 1'b0);
      send(3'd5, 16'h0, 32'h80FF7F01, 2'd0, 5'd8, 32'h00007F01, 1'b0);
      send(3'd7, 16'h0, 32'h80FF7F01, 2'd0, 5'd9, 32'h80FF7F01, 1'b0);
      send(3'd5, 16'h0, 32'h80FF7F01, 2'd1, 5'd10, 32'h0, 1'b1);
      send(3'd7, 16'h0, 32'h80FF7F01, 2'd2, 5'd11, 32'h0, 1'b1);
      send(3'd1, 16'h7FFF, 32'h80FF7F01, 2'd3, 5'd12, 32'h00007FFF, 1'b0);
      send(3'd2, 16'h8001, 32'h0, 2'd0, 5'd13, 32'h80010000, 1'b0);
      send(3'd6, 16'h0, 32'h1234ABCD, 2'd0, 5'd14, 32'hFFFFABCD, 1'b0);
      drain();

      popped = 0;
      fork
         begin
            send(3'd0, 16'h0001, 32'h0, 2'd0, 5'd1, 32'h00000001, 1'b0);
            send(3'd1, 16'hFFFF, 32'h0, 2'd0, 5'd2, 32'hFFFFFFFF, 1'b0);
            send(3'd3, 16'h0, 32'h000000AB, 2'd0, 5'd3, 32'h000000AB, 1'b0);
            send(3'd7, 16'h0, 32'hDEADBEEF, 2'd0, 5'd4, 32'hDEADBEEF, 1'b0);
         end
         begin
            logic seen;
            logic [31:0] hd;
            logic [4:0] ht;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
               @(posedge clk);
               #1 seen = out_valid;
            end
            check("bp_seen", 32'(seen), 32'd1);
            out_ready = 1'b0;
            #1 hd = out_data;
            ht = out_tag;
            check("bp_first_tag", 32'(ht), 32'd1);
            repeat (3) begin
               @(posedge clk);
               #2 check("bp_ready", 32'(in_ready), 32'd0);
               check("bp_valid", 32'(out_valid), 32'd1);
               check("bp_data", out_data, hd);
               check("bp_tag", 32'(out_tag), 32'(ht));
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 32'(popped), 32'd4);

      out_ready = 1'b0;
      send(3'd7, 16'h0, 32'hCAFEF00D, 2'd0, 5'd20, 32'hCAFEF00D, 1'b0);
      send(3'd0, 16'h5555, 32'h0, 2'd0, 5'd21, 32'h00005555, 1'b0);
      check("full_ready", 32'(in_ready), 32'd0);
      in_op = 3'd0; in_imm = 16'h0042; in_tag = 5'd22; in_valid = 1'b1;
      flush = 1'b1;
      out_ready = 1'b1;
      #1 check("flush_hs_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      #1 check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_ready", 32'(in_ready), 32'd1);
      repeat (4) begin
         @(posedge clk);
         #1 check("flush_quiet", 32'(out_valid), 32'd0);
      end

      send(3'd1, 16'h0001, 32'h0, 2'd0, 5'd23, 32'h00000001, 1'b0);
      send(3'd0, 16'h0002, 32'h0, 2'd0, 5'd24, 32'h00000002, 1'b0);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rstn = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", out_data, 32'd0);
      check("mid_rst_tag", 32'(out_tag), 32'd0);
      check("mid_rst_mis", 32'(out_misalign), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1 check("rel2_ready", 32'(in_ready), 32'd1);
      send_lat(3'd2, 16'hFFFF, 5'd25, 32'hFFFF0000);

      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
